// File: rtl/simmem_pkg.sv
// -----------------------------------------------------------------------------
// simmem_pkg
// Shared types for the simulated-memory path. The payload structs, field
// widths and the responder FSM state encodings are defined only here.
//   raddr_t : read address   (id, addr, burst_len)
//   waddr_t : write address  (id, addr)
//   wdata_t : write beat     (data, last)
//   rdata_t : read beat      (id, data, last)
//   wrsp_t  : write response (id)
// -----------------------------------------------------------------------------
package simmem_pkg;

   localparam int unsigned IdW              = 4;
   localparam int unsigned AddrW            = 16;
   localparam int unsigned DataW            = 16;
   localparam int unsigned MaxBurstLenField = 16;
   localparam int unsigned BurstLenW        = $clog2(MaxBurstLenField);
   // Wide enough for a latency countdown start value of up to 14 (RspLatency 15).
   localparam int unsigned RspLatencyW      = 4;

   typedef struct packed {
      logic [IdW-1:0]       id;
      logic [AddrW-1:0]     addr;
      logic [BurstLenW-1:0] burst_len;
   } raddr_t;

   typedef struct packed {
      logic [IdW-1:0]   id;
      logic [AddrW-1:0] addr;
   } waddr_t;

   typedef struct packed {
      logic [DataW-1:0] data;
      logic             last;
   } wdata_t;

   typedef struct packed {
      logic [IdW-1:0]   id;
      logic [DataW-1:0] data;
      logic             last;
   } rdata_t;

   typedef struct packed {
      logic [IdW-1:0] id;
   } wrsp_t;

   typedef enum logic [1:0] {
      R_IDLE  = 2'd0,
      R_WAIT  = 2'd1,
      R_BURST = 2'd2
   } rstate_e;

   typedef enum logic [1:0] {
      W_IDLE = 2'd0,
      W_DATA = 2'd1,
      W_WAIT = 2'd2,
      W_RSP  = 2'd3
   } wstate_e;

endpackage

// File: rtl/simmem_mem_responder_fifo.sv
// -----------------------------------------------------------------------------
// simmem_mem_responder_fifo
// Registered FIFO holding queued address requests. A push while full is
// dropped even if a pop happens in the same cycle, so the upstream ready can
// be derived from full_o alone.
//   clk_i, rst_ni : clock, async active-low reset (empties the FIFO)
//   push_i        : write push_data_i when not full
//   pop_i         : discard head_o when not empty
//   head_o        : oldest entry (valid while !empty_o)
//   full_o/empty_o: occupancy flags
// -----------------------------------------------------------------------------
module simmem_mem_responder_fifo #(
   parameter type         T     = logic,
   parameter int unsigned Depth = 4
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic push_i,
   input  T     push_data_i,
   input  logic pop_i,
   output T     head_o,
   output logic full_o,
   output logic empty_o
);

   localparam int unsigned PtrW = $clog2(Depth);

   T              mem_q [Depth];
   // Pointers carry one extra wrap bit to tell full from empty.
   logic [PtrW:0] wptr_q, wptr_d;
   logic [PtrW:0] rptr_q, rptr_d;
   logic          push_ok;
   logic          pop_ok;

   assign full_o  = (wptr_q[PtrW] != rptr_q[PtrW]) &&
                    (wptr_q[PtrW-1:0] == rptr_q[PtrW-1:0]);
   assign empty_o = (wptr_q == rptr_q);
   assign push_ok = push_i && !full_o;
   assign pop_ok  = pop_i && !empty_o;
   assign head_o  = mem_q[rptr_q[PtrW-1:0]];

   always_comb begin
      wptr_d = wptr_q;
      rptr_d = rptr_q;
      if (push_ok) wptr_d = wptr_q + 1'b1;
      if (pop_ok)  rptr_d = rptr_q + 1'b1;
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wptr_q <= '0;
         rptr_q <= '0;
      end else begin
         wptr_q <= wptr_d;
         rptr_q <= rptr_d;
      end
   end

   // Storage needs no reset: an entry is only read after it was written.
   always_ff @(posedge clk_i) begin
      if (push_ok) mem_q[wptr_q[PtrW-1:0]] <= push_data_i;
   end

endmodule

// File: rtl/simmem_mem_responder.sv
// -----------------------------------------------------------------------------
// simmem_mem_responder
// Deterministic memory model: queues read/write addresses, then returns read
// bursts (data = beat index) and write responses after a fixed latency.
// Handshakes: a transfer happens on a rising edge with valid && ready; valid
// and payload hold until the transfer; no ready depends combinationally on a
// valid input.
//   raddr_i/valid/ready  : read request in (id, burst_len used)
//   waddr_i/valid/ready  : write request in (id used)
//   wdata_i/valid/ready  : write beats in (last used), accepted only in W_DATA
//   rdata_o/valid/ready  : read beats out (id, zero-extended beat, last)
//   wrsp_o/valid/ready   : write response out (id)
//   dbg_rstate_o/dbg_wstate_o : current read/write FSM state
// RspLatency must be 1..15; AddrQueueDepth a power of two >= 2.
// -----------------------------------------------------------------------------
module simmem_mem_responder
   import simmem_pkg::*;
#(
   parameter int unsigned RspLatency     = 2,
   parameter int unsigned AddrQueueDepth = 4
) (
   input  logic    clk_i,
   input  logic    rst_ni,
   input  raddr_t  raddr_i,
   input  logic    raddr_valid_i,
   output logic    raddr_ready_o,
   input  waddr_t  waddr_i,
   input  logic    waddr_valid_i,
   output logic    waddr_ready_o,
   input  wdata_t  wdata_i,
   input  logic    wdata_valid_i,
   output logic    wdata_ready_o,
   output rdata_t  rdata_o,
   output logic    rdata_valid_o,
   input  logic    rdata_ready_i,
   output wrsp_t   wrsp_o,
   output logic    wrsp_valid_o,
   input  logic    wrsp_ready_i,
   output rstate_e dbg_rstate_o,
   output wstate_e dbg_wstate_o
);

   localparam logic [RspLatencyW-1:0] LatInit = RspLatencyW'(RspLatency - 1);

   // Address readies stay low while in reset and rise on the first edge after.
   logic   ready_en_q;
   raddr_t rhead;
   waddr_t whead;
   logic   rfifo_full, rfifo_empty, rfifo_pop;
   logic   wfifo_full, wfifo_empty, wfifo_pop;

   assign raddr_ready_o = ready_en_q && !rfifo_full;
   assign waddr_ready_o = ready_en_q && !wfifo_full;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) ready_en_q <= 1'b0;
      else         ready_en_q <= 1'b1;
   end

   simmem_mem_responder_fifo #(.T(raddr_t), .Depth(AddrQueueDepth)) u_rfifo (
      .clk_i       (clk_i),
      .rst_ni      (rst_ni),
      .push_i      (raddr_valid_i && raddr_ready_o),
      .push_data_i (raddr_i),
      .pop_i       (rfifo_pop),
      .head_o      (rhead),
      .full_o      (rfifo_full),
      .empty_o     (rfifo_empty)
   );

   simmem_mem_responder_fifo #(.T(waddr_t), .Depth(AddrQueueDepth)) u_wfifo (
      .clk_i       (clk_i),
      .rst_ni      (rst_ni),
      .push_i      (waddr_valid_i && waddr_ready_o),
      .push_data_i (waddr_i),
      .pop_i       (wfifo_pop),
      .head_o      (whead),
      .full_o      (wfifo_full),
      .empty_o     (wfifo_empty)
   );

   // ---------------- read path ----------------
   rstate_e                rstate_q, rstate_d;
   logic [IdW-1:0]         rid_q, rid_d;
   logic [BurstLenW-1:0]   rlen_q, rlen_d;
   logic [BurstLenW-1:0]   rbeat_q, rbeat_d;
   logic [RspLatencyW-1:0] rlat_q, rlat_d;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         rstate_q <= R_IDLE;
         rid_q    <= '0;
         rlen_q   <= '0;
         rbeat_q  <= '0;
         rlat_q   <= '0;
      end else begin
         rstate_q <= rstate_d;
         rid_q    <= rid_d;
         rlen_q   <= rlen_d;
         rbeat_q  <= rbeat_d;
         rlat_q   <= rlat_d;
      end
   end

   always_comb begin
      rstate_d = rstate_q;
      rid_d    = rid_q;
      rlen_d   = rlen_q;
      rbeat_d  = rbeat_q;
      rlat_d   = rlat_q;
      case (rstate_q)
         R_IDLE: begin
            if (!rfifo_empty) begin
               rid_d    = rhead.id;
               rlen_d   = rhead.burst_len;
               rlat_d   = LatInit;
               rstate_d = R_WAIT;
            end
         end
         R_WAIT: begin
            if (rlat_q == '0) begin
               rbeat_d  = '0;
               rstate_d = R_BURST;
            end else begin
               rlat_d = rlat_q - 1'b1;
            end
         end
         R_BURST: begin
            // Beat never exceeds burst_len, so the counter cannot wrap.
            if (rdata_ready_i) begin
               if (rbeat_q == rlen_q) rstate_d = R_IDLE;
               else                   rbeat_d  = rbeat_q + 1'b1;
            end
         end
         default: rstate_d = R_IDLE;
      endcase
   end

   always_comb begin
      rdata_valid_o = 1'b0;
      rdata_o       = '0;
      rfifo_pop     = (rstate_q == R_IDLE) && !rfifo_empty;
      if (rstate_q == R_BURST) begin
         rdata_valid_o = 1'b1;
         rdata_o.id    = rid_q;
         rdata_o.data  = DataW'(rbeat_q);
         rdata_o.last  = (rbeat_q == rlen_q);
      end
   end

   assign dbg_rstate_o = rstate_q;

   // ---------------- write path ----------------
   wstate_e                wstate_q, wstate_d;
   logic [IdW-1:0]         wid_q, wid_d;
   logic [RspLatencyW-1:0] wlat_q, wlat_d;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wstate_q <= W_IDLE;
         wid_q    <= '0;
         wlat_q   <= '0;
      end else begin
         wstate_q <= wstate_d;
         wid_q    <= wid_d;
         wlat_q   <= wlat_d;
      end
   end

   always_comb begin
      wstate_d = wstate_q;
      wid_d    = wid_q;
      wlat_d   = wlat_q;
      case (wstate_q)
         W_IDLE: begin
            if (!wfifo_empty) begin
               wid_d    = whead.id;
               wstate_d = W_DATA;
            end
         end
         W_DATA: begin
            // Data beats are consumed and discarded; only last matters.
            if (wdata_valid_i && wdata_i.last) begin
               wlat_d   = LatInit;
               wstate_d = W_WAIT;
            end
         end
         W_WAIT: begin
            if (wlat_q == '0) wstate_d = W_RSP;
            else              wlat_d   = wlat_q - 1'b1;
         end
         W_RSP: begin
            if (wrsp_ready_i) wstate_d = W_IDLE;
         end
         default: wstate_d = W_IDLE;
      endcase
   end

   always_comb begin
      wfifo_pop     = (wstate_q == W_IDLE) && !wfifo_empty;
      wdata_ready_o = (wstate_q == W_DATA);
      wrsp_valid_o  = (wstate_q == W_RSP);
      wrsp_o        = '0;
      if (wstate_q == W_RSP) wrsp_o.id = wid_q;
   end

   assign dbg_wstate_o = wstate_q;

   // Address and write-data payload fields are carried but not modelled.
   logic unused_fields;
   assign unused_fields = ^{rhead.addr, whead.addr, wdata_i.data};

endmodule
